// File: rtl/add_tree_pkg.sv
// add_tree_pkg: sizing helpers shared by the pipelined adder tree and its stages
package add_tree_pkg;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    // a single operand still gets one register stage
    function automatic int n_stages(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction
    // number of values entering stage s
    function automatic int stage_m(input int n, input int s);
        int m = n;
        for (int i = 0; i < s; i++) m = (m + 1) / 2;
        return m;
    endfunction
    // register width of stage s; s = -1 yields the operand width
    function automatic int stage_w(input int width, input int grow, input int s);
        return (grow != 0) ? width + s + 1 : width;
    endfunction
    function automatic int out_w(input int n, input int width, input int grow);
        return (grow != 0) ? width + clog2(n) : width;
    endfunction
endpackage

// File: rtl/add_tree_stage.sv
// add_tree_stage: one registered layer of pairwise adders with an odd pass-through
// Ports: clk, rst (sync, active-high); i_tag/i_data enter, o_tag/o_data leave one cycle later.
// i_tag carries valid (bit 0) plus any side-band bits that must stay aligned with the data.
module add_tree_stage import add_tree_pkg::*; #(
    parameter int M_IN  = 2,
    parameter int W_IN  = 8,
    parameter int W_OUT = 8,
    parameter int TAG_W = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [TAG_W-1:0]                i_tag,
    input  logic [M_IN*W_IN-1:0]            i_data,
    output logic [TAG_W-1:0]                o_tag,
    output logic [((M_IN+1)/2)*W_OUT-1:0]   o_data
);
    localparam int M_OUT = (M_IN + 1) / 2;
    logic [M_OUT*W_OUT-1:0] w_next;
    logic [M_OUT*W_OUT-1:0] r_data;
    logic [TAG_W-1:0]       r_tag;
    for (genvar j = 0; j < M_OUT; j++) begin : g_el
        if (2 * j + 1 < M_IN) begin : g_add
            assign w_next[j*W_OUT +: W_OUT] = W_OUT'(i_data[2*j*W_IN +: W_IN])
                                            + W_OUT'(i_data[(2*j+1)*W_IN +: W_IN]);
        end else begin : g_pass
            // odd leftover is only registered so every path has equal depth
            assign w_next[j*W_OUT +: W_OUT] = W_OUT'(i_data[2*j*W_IN +: W_IN]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_tag  <= '0;
        end else begin
            r_data <= w_next;
            r_tag  <= i_tag;
        end
    end
    assign o_data = r_data;
    assign o_tag  = r_tag;
endmodule

// File: rtl/add_tree_pipe.sv
// add_tree_pipe: fully pipelined binary adder tree summing N_IN unsigned WIDTH-bit operands
// Ports: clk, rst (sync, active-high); in_valid/in_data (operand k = in_data[k*WIDTH +: WIDTH]);
// out_valid/out_data (OUT_W bits, latency S = max(1, clog2(N_IN))).
// Option ADD_TREE_ACC_EN: adds in_first/in_last and a group accumulator after the tree (latency S+1).
module add_tree_pipe import add_tree_pkg::*; #(
    parameter int N_IN  = 26,
    parameter int WIDTH = 512,
    parameter int GROW  = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
`ifdef ADD_TREE_ACC_EN
    input  logic                                  in_first,
    input  logic                                  in_last,
`endif
    input  logic [N_IN*WIDTH-1:0]                 in_data,
    output logic                                  out_valid,
    output logic [out_w(N_IN, WIDTH, GROW)-1:0]   out_data
);
    localparam int S     = n_stages(N_IN);
    localparam int OUT_W = out_w(N_IN, WIDTH, GROW);
    localparam int W_F   = stage_w(WIDTH, GROW, S - 1);
`ifdef ADD_TREE_ACC_EN
    localparam int TAG_W = 3;
    logic [TAG_W-1:0] w_tag_in;
    assign w_tag_in = {in_last, in_first, in_valid};
`else
    localparam int TAG_W = 1;
    logic [TAG_W-1:0] w_tag_in;
    assign w_tag_in = in_valid;
`endif
    for (genvar s = 0; s < S; s++) begin : g_st
        localparam int M_I = stage_m(N_IN, s);
        localparam int W_I = stage_w(WIDTH, GROW, s - 1);
        localparam int M_O = (M_I + 1) / 2;
        localparam int W_O = stage_w(WIDTH, GROW, s);
        logic [M_I*W_I-1:0] w_in;
        logic [TAG_W-1:0]   w_tin;
        logic [M_O*W_O-1:0] w_out;
        logic [TAG_W-1:0]   w_tag;
        if (s == 0) begin : g_head
            assign w_in  = in_data;
            assign w_tin = w_tag_in;
        end else begin : g_link
            assign w_in  = g_st[s-1].w_out;
            assign w_tin = g_st[s-1].w_tag;
        end
        add_tree_stage #(
            .M_IN (M_I),
            .W_IN (W_I),
            .W_OUT(W_O),
            .TAG_W(TAG_W)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .i_tag (w_tin),
            .i_data(w_in),
            .o_tag (w_tag),
            .o_data(w_out)
        );
    end
    logic [W_F-1:0]   w_tree;
    logic [TAG_W-1:0] w_tree_tag;
    logic [OUT_W-1:0] w_sum;
    assign w_tree     = g_st[S-1].w_out;
    assign w_tree_tag = g_st[S-1].w_tag;
    // the final width is never narrower than OUT_W; a lone grown operand is cut back
    assign w_sum      = w_tree[OUT_W-1:0];
`ifdef ADD_TREE_ACC_EN
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_acc_next;
    logic             r_out_valid;
    // first restarts the group; otherwise keep adding onto whatever acc holds
    assign w_acc_next = w_tree_tag[1] ? w_sum : r_acc + w_sum;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_tree_tag[0] & w_tree_tag[2];
            if (w_tree_tag[0]) r_acc <= w_acc_next;
        end
    end
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
`else
    assign out_valid = w_tree_tag[0];
    assign out_data  = w_sum;
`endif
endmodule

// File: tb/tb_add_tree_pipe.sv
// tb_add_tree_pipe: scoreboard bench for add_tree_pipe across several operand counts and widths
module tb_add_tree_pipe;
    typedef struct {
        int             c;
        logic [519:0]   d;
    } exp_t;
`ifdef ADD_TREE_ACC_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif
    exp_t q[7][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_chk = 1'b0;
    logic done = 1'b0;
    logic va = 1'b0, vc = 1'b0, vd = 1'b0, ve = 1'b0, vf = 1'b0;
    logic [26*512-1:0] da = '0;
    logic [7:0]        dc = '0;
    logic [23:0]       dd = '0;
    logic [64*16-1:0]  de = '0;
    logic [15:0]       df = '0;
    logic ova, ovb, ovc, ovd, ove, ovf;
    logic [511:0] oda;
    logic [516:0] odb;
    logic [7:0]   odc, odd, odf;
    logic [15:0]  ode;
`ifdef ADD_TREE_ACC_EN
    logic vg = 1'b0, fg = 1'b0, lg = 1'b0;
    logic [31:0] dg = '0;
    logic ovg;
    logic [7:0] odg;
    add_tree_pipe #(.N_IN(4), .WIDTH(8), .GROW(0)) u_g (
        .clk(clk), .rst(rst), .in_valid(vg), .in_first(fg), .in_last(lg),
        .in_data(dg), .out_valid(ovg), .out_data(odg));
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_tree_pipe #(.N_IN(26), .WIDTH(512), .GROW(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(va),
`ifdef ADD_TREE_ACC_EN
        .in_first(1'b1), .in_last(1'b1),
`endif
        .in_data(da), .out_valid(ova), .out_data(oda));
    add_tree_pipe #(.N_IN(26), .WIDTH(512), .GROW(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(va),
`ifdef ADD_TREE_ACC_EN
        .in_first(1'b1), .in_last(1'b1),
`endif
        .in_data(da), .out_valid(ovb), .out_data(odb));
    add_tree_pipe #(.N_IN(1), .WIDTH(8), .GROW(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(vc),
`ifdef ADD_TREE_ACC_EN
        .in_first(1'b1), .in_last(1'b1),
`endif
        .in_data(dc), .out_valid(ovc), .out_data(odc));
    add_tree_pipe #(.N_IN(3), .WIDTH(8), .GROW(0)) u_d (
        .clk(clk), .rst(rst), .in_valid(vd),
`ifdef ADD_TREE_ACC_EN
        .in_first(1'b1), .in_last(1'b1),
`endif
        .in_data(dd), .out_valid(ovd), .out_data(odd));
    add_tree_pipe #(.N_IN(64), .WIDTH(16), .GROW(0)) u_e (
        .clk(clk), .rst(rst), .in_valid(ve),
`ifdef ADD_TREE_ACC_EN
        .in_first(1'b1), .in_last(1'b1),
`endif
        .in_data(de), .out_valid(ove), .out_data(ode));
    add_tree_pipe #(.N_IN(2), .WIDTH(8), .GROW(0)) u_f (
        .clk(clk), .rst(rst), .in_valid(vf),
`ifdef ADD_TREE_ACC_EN
        .in_first(1'b1), .in_last(1'b1),
`endif
        .in_data(df), .out_valid(ovf), .out_data(odf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int lat, input logic [519:0] d);
        exp_t e;
        e.c = cyc + lat + XL;
        e.d = d;
        q[id].push_back(e);
    endtask

    task automatic chk(input string nm, input logic [519:0] a, input logic [519:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, a, e);
        end
    endtask

    task automatic mon(input int id, input string nm, input logic v, input logic [519:0] d);
        exp_t e;
        if (v) begin
            if (q[id].size() == 0) begin
                chk({nm, " unexpected out_valid"}, 520'(v), 520'(0));
            end else begin
                e = q[id].pop_front();
                chk({nm, " data"}, d, e.d);
                chk({nm, " cycle"}, 520'(cyc), 520'(e.c));
            end
        end else if (q[id].size() != 0 && q[id][0].c <= cyc) begin
            e = q[id].pop_front();
            chk({nm, " missing out_valid"}, 520'(v), 520'(1));
        end
    endtask

    always @(negedge clk) begin
        mon(0, "n26", ova, 520'(oda));
        mon(1, "n26_grow", ovb, 520'(odb));
        mon(2, "n1", ovc, 520'(odc));
        mon(3, "n3", ovd, 520'(odd));
        mon(4, "n64", ove, 520'(ode));
        mon(5, "n2", ovf, 520'(odf));
`ifdef ADD_TREE_ACC_EN
        mon(6, "acc", ovg, 520'(odg));
`endif
        if (rst_chk) begin
            chk("reset n26 valid", 520'(ova), 520'(0));
            chk("reset n26 data", 520'(oda), 520'(0));
            chk("reset n26_grow data", 520'(odb), 520'(0));
            chk("reset n1 data", 520'(odc), 520'(0));
            chk("reset n64 valid", 520'(ove), 520'(0));
        end
        if (done) begin
            for (int i = 0; i < 7; i++)
                chk($sformatf("queue %0d drained", i), 520'(q[i].size()), 520'(0));
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        logic [519:0] s;
        logic [519:0] ones;
        ones = '0;
        ones[511:0] = '1;
        repeat (2) tick();
        rst_chk = 1'b1;
        tick();
        rst_chk = 1'b0;
        rst = 1'b0;
        tick();
        // operand k = k: 0+1+...+25
        for (int k = 0; k < 26; k++) da[k*512 +: 512] = 512'(k);
        va = 1'b1;
        push(0, 5, 520'd325);
        push(1, 5, 520'd325);
        tick();
        va = 1'b0;
        repeat (7) tick();
        // all operands at maximum
        da = '1;
        va = 1'b1;
        push(0, 5, ones - 520'd25);
        push(1, 5, ones * 520'd26);
        tick();
        va = 1'b0;
        repeat (7) tick();
        // 100 back-to-back random beats, a two-cycle gap, then three more
        for (int i = 0; i < 105; i++) begin
            va = (i < 100 || i >= 102);
            for (int w = 0; w < 416; w++) da[w*32 +: 32] = $urandom;
            s = '0;
            for (int k = 0; k < 26; k++) s += 520'(da[k*512 +: 512]);
            if (va) begin
                push(0, 5, 520'(s[511:0]));
                push(1, 5, s);
            end
            tick();
        end
        va = 1'b0;
        repeat (7) tick();
        // reset while three beats are in flight; the third arrives with rst high
        va = 1'b1;
        da = '1;
        tick();
        for (int k = 0; k < 26; k++) da[k*512 +: 512] = 512'(k + 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        va = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 26; k++) da[k*512 +: 512] = 512'(k);
        va = 1'b1;
        push(0, 5, 520'd325);
        push(1, 5, 520'd325);
        tick();
        va = 1'b0;
        repeat (7) tick();
        // edge sizes: N_IN = 1, 3, 64, 2
        vc = 1'b1; dc = 8'hA5; push(2, 1, 520'hA5);
        vd = 1'b1; dd = {8'd50, 8'd100, 8'd200}; push(3, 2, 520'd94);
        ve = 1'b1;
        for (int k = 0; k < 64; k++) de[k*16 +: 16] = 16'(k);
        push(4, 6, 520'd2016);
        vf = 1'b1; df = {8'd1, 8'd255}; push(5, 1, 520'd0);
        tick();
        dc = 8'h00; push(2, 1, 520'd0);
        dd = {8'd3, 8'd2, 8'd1}; push(3, 2, 520'd6);
        de = '1; push(4, 6, 520'd65472);
        df = {8'd4, 8'd3}; push(5, 1, 520'd7);
        tick();
        dc = 8'hFF; push(2, 1, 520'd255);
        vd = 1'b0; ve = 1'b0; vf = 1'b0;
        tick();
        vc = 1'b0;
        repeat (8) tick();
`ifdef ADD_TREE_ACC_EN
        // group of three beats: 4 + 8 + 12, then a single first&last beat
        vg = 1'b1; fg = 1'b1; lg = 1'b0; dg = {4{8'd1}};
        tick();
        fg = 1'b0; dg = {4{8'd2}};
        tick();
        lg = 1'b1; dg = {4{8'd3}}; push(6, 2, 520'd24);
        tick();
        fg = 1'b1; dg = {8'd0, 8'd1, 8'd255, 8'd255}; push(6, 2, 520'd255);
        tick();
        vg = 1'b0; fg = 1'b0; lg = 1'b0;
        repeat (6) tick();
`endif
        done = 1'b1;
        repeat (4) tick();
        $display("FAIL summary not reached");
        $fatal(1);
    end
endmodule
